// File: rtl/queue_pkg.sv
// queue_pkg: shared FSM state encoding and default widths for queue_ctrl
package queue_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
endpackage

// File: rtl/queue_ctrl_if.sv
// queue_ctrl_if: push/pop handshakes, flush, storage port and status of queue_ctrl; slave = controller side, master = user/storage side
interface queue_ctrl_if
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   peak_count;
  modport slave (
    input  push_valid, push_data, pop_ready, flush, mem_rdata,
    output push_ready, pop_valid, pop_data, mem_addr, mem_data, mem_we, count, full, empty, peak_count
  );
  modport master (
    output push_valid, push_data, pop_ready, flush, mem_rdata,
    input  push_ready, pop_valid, pop_data, mem_addr, mem_data, mem_we, count, full, empty, peak_count
  );
endinterface

// File: rtl/queue_ctrl.sv
// queue_ctrl: FIFO controller over external single-port storage; ports clk, rst, q (queue_ctrl_if.slave: push/pop handshakes, flush, mem port, count/full/empty/peak_count); QUEUE_CTRL_STATS_EN enables peak_count tracking
module queue_ctrl
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic        clk,
  input logic        rst,
  queue_ctrl_if.slave q
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  full, empty, pop_hs, push_hs, push_ready, read_issue;
  always_comb begin
    full       = count_q == DEPTH;
    empty      = count_q == '0;
    pop_hs     = state_q == HOLD && q.pop_ready && !q.flush && !rst;
    read_issue = !rst && !q.flush && ((state_q == IDLE && !empty) || (pop_hs && count_q > CW'(1)));
    push_ready = !full && !rst && !q.flush && !read_issue;
    push_hs    = q.push_valid && push_ready;
    state_d    = q.flush ? IDLE : read_issue ? FETCH : state_q == FETCH ? HOLD : pop_hs ? IDLE : state_q;
    wr_ptr_d   = q.flush ? '0 : wr_ptr_q + ADDR_WIDTH'(push_hs);
    rd_ptr_d   = q.flush ? '0 : rd_ptr_q + ADDR_WIDTH'(state_q == FETCH);
    count_d    = q.flush ? '0 : count_q + CW'(push_hs) - CW'(pop_hs);
    pop_data_d = state_q == FETCH && !q.flush ? q.mem_rdata : pop_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
    end
  end
  assign q.push_ready = push_ready;
  assign q.pop_valid  = state_q == HOLD;
  assign q.pop_data   = pop_data_q;
  assign q.mem_we     = push_hs;
  assign q.mem_addr   = push_hs ? wr_ptr_q : rd_ptr_q;
  assign q.mem_data   = q.push_data;
  assign q.count      = count_q;
  assign q.full       = full;
  assign q.empty      = empty;
`ifdef QUEUE_CTRL_STATS_EN
  logic [CW-1:0] peak_q;
  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= count_d > peak_q ? count_d : peak_q;
  end
  assign q.peak_count = peak_q;
`else
  assign q.peak_count = '0;
`endif
endmodule
